// File: rtl/and_serial_rx_pkg.sv
// Shared types and sizing helpers for the AND serial receiver.
package and_serial_rx_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  // Counter width; a single-bit word still needs a 1-bit counter.
  function automatic int cntWidth(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/and_serial_rx_bit_counter.sv
// Bit position counter for one serial word; clears itself after the last bit.
module bit_counter
  import and_serial_rx_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = cntWidth(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] r_cnt;

  // Restarting at the last index means the count never goes past WIDTH-1.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= last ? '0 : r_cnt + 1'b1;
    end
  end

  assign cnt  = r_cnt;
  assign last = (r_cnt == LAST_IDX);

endmodule

// File: rtl/and_serial_rx.sv
// Serial receiver that reduces each WIDTH-bit word to the AND of its bits.
// Define AND_SERIAL_RX_ZIDX_EN to also report the index of the first zero bit.
module and_serial_rx
  import and_serial_rx_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = cntWidth(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_y
`ifdef AND_SERIAL_RX_ZIDX_EN
  ,
  output logic [CNT_W-1:0] out_zidx
`endif
);

  state_t           r_state;
  state_t           w_nextState;
  logic             r_acc;
  logic             r_outY;
  logic             w_accept;
  logic             w_handshake;
  logic             w_last;
  logic             w_accBit;
  logic [CNT_W-1:0] w_cnt;

  // Handshake outputs depend only on the state register.
  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid && w_last) w_nextState = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_nextState = COLLECT;
      end
      default: w_nextState = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= COLLECT;
    else          r_state <= w_nextState;
  end

  assign w_accept    = in_valid & in_ready;
  assign w_handshake = out_valid & out_ready;
  assign w_accBit    = r_acc & in_bit;

  bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (w_handshake),
    .inc     (w_accept),
    .cnt     (w_cnt),
    .last    (w_last)
  );

  // The accumulator is re-armed on the final bit, so HOLD always leaves it at 1.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_acc  <= 1'b1;
      r_outY <= 1'b0;
    end else if (w_accept) begin
      if (w_last) begin
        r_outY <= w_accBit;
        r_acc  <= 1'b1;
      end else begin
        r_acc  <= w_accBit;
      end
    end
  end

  assign out_y = r_outY;

`ifdef AND_SERIAL_RX_ZIDX_EN
  logic             r_seenZero;
  logic [CNT_W-1:0] r_firstZero;
  logic [CNT_W-1:0] r_outZidx;
  logic             w_seenNext;
  logic [CNT_W-1:0] w_zidxNext;

  assign w_seenNext = r_seenZero | ~in_bit;
  assign w_zidxNext = (r_seenZero || in_bit) ? r_firstZero : w_cnt;

  // A word with no zero bit reports index 0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_seenZero  <= 1'b0;
      r_firstZero <= '0;
      r_outZidx   <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_outZidx   <= w_seenNext ? w_zidxNext : '0;
        r_seenZero  <= 1'b0;
        r_firstZero <= '0;
      end else begin
        r_seenZero  <= w_seenNext;
        r_firstZero <= w_zidxNext;
      end
    end
  end

  assign out_zidx = r_outZidx;
`else
  logic w_unused_cnt;
  assign w_unused_cnt = ^w_cnt;
`endif

endmodule
